// File: rtl/word_to_byte_fifo.sv
// Word-in, byte-out FIFO between a CPU (pushes WORD_WIDTH-bit words) and a debugger
// (consumes bytes LSB first), with occupancy flags, sticky overflow and synchronous flush.
module word_to_byte_fifo #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       LD,
    input  logic [WORD_WIDTH-1:0]      D,
    input  logic                       RD,
    input  logic                       CLR,
    output logic [7:0]                 Q,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic                       OVF,
    output logic [$clog2(DEPTH):0]     COUNT
);

    localparam int BYTES = WORD_WIDTH / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BW-1:0] LAST_BP    = BW'(BYTES - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [BW-1:0]         byte_ptr;

    logic                  rd_ok;
    logic                  pop;
    logic                  push;
    logic                  ovf_set;
    logic [WORD_WIDTH-1:0] head_shift;

    assign EMPTY = (COUNT == '0);
    assign FULL  = (COUNT == FULL_COUNT);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is still
    // accepted when the last byte of the head word is being consumed.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        rd_ok      = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        ovf_set    = 1'b0;
        head_shift = '0;
        Q          = 8'h00;
        if (!CLR) begin
            rd_ok   = RD && !EMPTY;
            pop     = rd_ok && (byte_ptr == LAST_BP);
            push    = LD && (!FULL || pop);
            ovf_set = LD && FULL && !pop;
        end
        if (!EMPTY) begin
            head_shift = mem[rd_ptr] >> {byte_ptr, 3'b000};
            Q          = head_shift[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every always_ff samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_ptr <= '0;
            COUNT    <= '0;
            OVF      <= 1'b0;
        end else if (CLR) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            byte_ptr <= '0;
            COUNT    <= '0;
            OVF      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                byte_ptr <= '0;
            end else if (rd_ok) begin
                byte_ptr <= byte_ptr + 1'b1;
            end
            if (ovf_set) begin
                OVF <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   COUNT <= COUNT + 1'b1;
                2'b01:   COUNT <= COUNT - 1'b1;
                default: COUNT <= COUNT;
            endcase
        end
    end

    // NOTE: storage has no reset; EMPTY masks Q, so stale contents are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= D;
        end
    end

endmodule
